// File: rtl/fsl_out_arbiter.sv
// fsl_out_arbiter
// Packet-granular round-robin arbiter that shares one registered 64-bit
// switch write port between two FSL-side packet sources. A granted source
// owns the port until it delivers its end-of-packet word. Packet boundaries
// come from the ctrl field: a nonzero ctrl word after at least one payload
// word ends the packet. One idle bubble cycle follows every packet. Tie
// breaks alternate between the sources, using the last-granted source.

module fsl_out_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  FSL_Clk,
    input  logic                  FSL_Rst,

    input  logic                  src0_wr,
    input  logic [DATA_WIDTH-1:0] src0_data,
    input  logic [CTRL_WIDTH-1:0] src0_ctrl,
    output logic                  src0_rdy,

    input  logic                  src1_wr,
    input  logic [DATA_WIDTH-1:0] src1_data,
    input  logic [CTRL_WIDTH-1:0] src1_ctrl,
    output logic                  src1_rdy,

    output logic                  out_wr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    input  logic                  in_rdy,

    output logic [1:0]            grant,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last;
    logic                  seen_pay;

    logic                  acc;
    logic                  eop;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [CTRL_WIDTH-1:0] acc_ctrl;

    logic [15:0]           cnt0_q;
    logic [15:0]           cnt1_q;

    // Owner-side handshake: ready, grant and the accepted-word mux follow the state.
    always_comb begin
        src0_rdy = 1'b0;
        src1_rdy = 1'b0;
        grant    = '0;
        acc      = 1'b0;
        acc_data = src0_data;
        acc_ctrl = src0_ctrl;
        case (state)
            OWN0: begin
                src0_rdy = in_rdy;
                grant    = 2'b01;
                acc      = src0_wr & in_rdy;
            end
            OWN1: begin
                src1_rdy = in_rdy;
                grant    = 2'b10;
                acc      = src1_wr & in_rdy;
                acc_data = src1_data;
                acc_ctrl = src1_ctrl;
            end
            default: begin
            end
        endcase
        // Header words carry nonzero ctrl too; only one seen after payload ends the packet.
        eop = acc & (acc_ctrl != '0) & seen_pay;
    end

    // Next-state: round-robin choice in IDLE, release the port on end of packet.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (src0_wr && src1_wr) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (src0_wr) begin
                    state_nxt = OWN0;
                end else if (src1_wr) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, last-granted source and payload-seen flag.
    always_ff @(posedge FSL_Clk) begin
        if (FSL_Rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            seen_pay <= 1'b0;
        end else begin
            state <= state_nxt;
            if (eop) begin
                last     <= (state == OWN1);
                seen_pay <= 1'b0;
            end else if (acc && (acc_ctrl == '0)) begin
                seen_pay <= 1'b1;
            end
        end
    end

    // Registered output port: one-cycle delayed copy of each accepted word.
    always_ff @(posedge FSL_Clk) begin
        if (FSL_Rst) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= acc;
            if (acc) begin
                out_data <= acc_data;
                out_ctrl <= acc_ctrl;
            end
        end
    end

    // Per-source completed-packet counters, wrapping naturally at 16 bits.
    always_ff @(posedge FSL_Clk) begin
        if (FSL_Rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (eop) begin
            if (state == OWN0) begin
                cnt0_q <= cnt0_q + 16'd1;
            end else begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule
